// File: rtl/cmp_result_collector.sv
// cmp_result_collector: decodes CMP_Out/CMP_Flag into relation codes and queues them in a show-ahead FIFO; `CMP_STATS_EN adds EQ/GT/LT counters.
// Latency: one cycle from the sampled result to RES_Valid/RES_Code (no empty-FIFO bypass); one result per cycle sustained.
// Backpressure: RES_Ready low holds the head stable; a result arriving while full with no pop is dropped and sets Overflow.
module cmp_result_collector #(
  parameter int Op_Width  = 16,
  parameter int Depth     = 4,
  parameter int Cnt_Width = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Op_Width-1:0]      CMP_Out,
  input  logic                     CMP_Flag,
  input  logic                     CLR,
  input  logic                     RES_Ready,
  output logic                     RES_Valid,
  output logic [2:0]               RES_Code,
  output logic [$clog2(Depth):0]   FIFO_Count,
  output logic                     Overflow
`ifdef CMP_STATS_EN
  ,
  output logic [Cnt_Width-1:0]     EQ_Cnt,
  output logic [Cnt_Width-1:0]     GT_Cnt,
  output logic [Cnt_Width-1:0]     LT_Cnt
`endif
);

  localparam int Ptr_Width = $clog2(Depth);

  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_EQ   = 3'b001;
  localparam logic [2:0] CODE_GT   = 3'b010;
  localparam logic [2:0] CODE_LT   = 3'b011;
  localparam logic [2:0] CODE_ERR  = 3'b100;

  localparam logic [Ptr_Width-1:0] Ptr_One  = Ptr_Width'(1);
  localparam logic [Ptr_Width:0]   Cnt_One  = (Ptr_Width + 1)'(1);
  localparam logic [Ptr_Width:0]   Full_Cnt = (Ptr_Width + 1)'(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0 || Cnt_Width < 1 || Op_Width < 2) begin : g_bad_cfg
    $error("cmp_result_collector: Depth must be a power of two >= 2, Op_Width >= 2, Cnt_Width >= 1");
  end

  logic [2:0]           in_code;
  logic [2:0]           mem [Depth];
  logic [Ptr_Width-1:0] wr_ptr;
  logic [Ptr_Width-1:0] rd_ptr;
  logic [Ptr_Width:0]   count;
  logic                 overflow_q;
  logic                 empty;
  logic                 full;
  logic                 do_pop;
  logic                 do_push;
  logic                 drop;

  // Any value other than 0..3, including nonzero upper bits, is an error code.
  always_comb begin
    in_code = CODE_ERR;
    if (CMP_Out == '0)
      in_code = CODE_NONE;
    else if (CMP_Out == Op_Width'(1))
      in_code = CODE_EQ;
    else if (CMP_Out == Op_Width'(2))
      in_code = CODE_GT;
    else if (CMP_Out == Op_Width'(3))
      in_code = CODE_LT;
  end

  assign empty   = (count == '0);
  assign full    = (count == Full_Cnt);
  assign do_pop  = !empty && RES_Ready;
  // A pop frees the slot the push needs, so full + pop still accepts the new result.
  assign do_push = CMP_Flag && (!full || do_pop);
  assign drop    = CMP_Flag && full && !do_pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + Ptr_One;
      if (do_pop)
        rd_ptr <= rd_ptr + Ptr_One;
      if (do_push && !do_pop)
        count <= count + Cnt_One;
      else if (do_pop && !do_push)
        count <= count - Cnt_One;
      if (drop)
        overflow_q <= 1'b1;
      else if (CLR)
        overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset: the output is gated by the count, which resets asynchronously.
  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr] <= in_code;
  end

  assign RES_Valid  = !empty;
  assign RES_Code   = empty ? CODE_NONE : mem[rd_ptr];
  assign FIFO_Count = count;
  assign Overflow   = overflow_q;

`ifdef CMP_STATS_EN
  localparam logic [Cnt_Width-1:0] Stat_One = Cnt_Width'(1);

  logic [Cnt_Width-1:0] eq_q;
  logic [Cnt_Width-1:0] gt_q;
  logic [Cnt_Width-1:0] lt_q;
  logic                 eq_inc;
  logic                 gt_inc;
  logic                 lt_inc;

  // Counted at decode time, so dropped results are still included.
  assign eq_inc = CMP_Flag && (in_code == CODE_EQ) && (eq_q != '1);
  assign gt_inc = CMP_Flag && (in_code == CODE_GT) && (gt_q != '1);
  assign lt_inc = CMP_Flag && (in_code == CODE_LT) && (lt_q != '1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      eq_q <= '0;
      gt_q <= '0;
      lt_q <= '0;
    end else if (CLR) begin
      eq_q <= '0;
      gt_q <= '0;
      lt_q <= '0;
    end else begin
      if (eq_inc)
        eq_q <= eq_q + Stat_One;
      if (gt_inc)
        gt_q <= gt_q + Stat_One;
      if (lt_inc)
        lt_q <= lt_q + Stat_One;
    end
  end

  assign EQ_Cnt = eq_q;
  assign GT_Cnt = gt_q;
  assign LT_Cnt = lt_q;
`endif

endmodule

// File: tb/tb_cmp_result_collector.sv
// Bench for cmp_result_collector: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_cmp_result_collector;

  localparam int DEPTH = 4;
`ifdef CMP_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] CMP_Out;
  logic        CMP_Flag;
  logic        CLR;
  logic        RES_Ready;
  logic        RES_Valid;
  logic [2:0]  RES_Code;
  logic [2:0]  FIFO_Count;
  logic        Overflow;
`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] EQ_Cnt;
  logic [CNT_W-1:0] GT_Cnt;
  logic [CNT_W-1:0] LT_Cnt;
`endif

  cmp_result_collector #(
    .Op_Width (16),
    .Depth    (DEPTH),
    .Cnt_Width(CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMP_Out   (CMP_Out),
    .CMP_Flag  (CMP_Flag),
    .CLR       (CLR),
    .RES_Ready (RES_Ready),
    .RES_Valid (RES_Valid),
    .RES_Code  (RES_Code),
    .FIFO_Count(FIFO_Count),
    .Overflow  (Overflow)
`ifdef CMP_STATS_EN
    ,
    .EQ_Cnt    (EQ_Cnt),
    .GT_Cnt    (GT_Cnt),
    .LT_Cnt    (LT_Cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  bit m_ovf;
  int m_eq, m_gt, m_lt;

  typedef struct {
    int out;
    int flag;
    int ready;
    int clr;
    int exp_vld;
    int exp_code;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  function automatic int ref_code(int v);
    if (v == 0) return 0;
    if (v == 1) return 1;
    if (v == 2) return 2;
    if (v == 3) return 3;
    return 4;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_eq = 0;
    m_gt = 0;
    m_lt = 0;
  endtask

  task automatic drive(int f, int v, int r, int c);
    CMP_Flag  = f[0];
    CMP_Out   = 16'(v);
    RES_Ready = r[0];
    CLR       = c[0];
  endtask

  // Advance one clock; the model consumes the inputs seen at that edge, outputs are sampled 1 unit later.
  task automatic tick();
    int c;
    int sat;
    @(posedge CLK);
    sat = (1 << CNT_W) - 1;
    c = ref_code(int'(CMP_Out));
    if (RES_Ready && q.size() > 0) void'(q.pop_front());
    if (CLR) begin
      m_ovf = 1'b0;
      m_eq = 0;
      m_gt = 0;
      m_lt = 0;
    end
    if (CMP_Flag) begin
      if (q.size() < DEPTH) q.push_back(c);
      else m_ovf = 1'b1;
      if (!CLR) begin
        if (c == 1 && m_eq < sat) m_eq++;
        if (c == 2 && m_gt < sat) m_gt++;
        if (c == 3 && m_lt < sat) m_lt++;
      end
    end
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".valid"}, int'(RES_Valid), (q.size() > 0) ? 1 : 0);
    chk({tag, ".code"}, int'(RES_Code), (q.size() > 0) ? q[0] : 0);
    chk({tag, ".count"}, int'(FIFO_Count), q.size());
    chk({tag, ".overflow"}, int'(Overflow), int'(m_ovf));
`ifdef CMP_STATS_EN
    chk({tag, ".eq_cnt"}, int'(EQ_Cnt), m_eq);
    chk({tag, ".gt_cnt"}, int'(GT_Cnt), m_gt);
    chk({tag, ".lt_cnt"}, int'(LT_Cnt), m_lt);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected the run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[10];
    int   ovf_codes[4];
    int   fp_codes[4];
    int   f, v, r, c;

    vt[0] = '{32'h0001, 1, 1, 0, 1, 1, 1, 0};
    vt[1] = '{32'h0002, 1, 1, 0, 1, 2, 1, 0};
    vt[2] = '{32'h0003, 1, 1, 0, 1, 3, 1, 0};
    vt[3] = '{32'h0000, 1, 1, 0, 1, 0, 1, 0};
    vt[4] = '{32'h0000, 0, 1, 0, 0, 0, 0, 0};
    vt[5] = '{32'h0100, 1, 0, 0, 1, 4, 1, 0};
    vt[6] = '{32'h0004, 1, 0, 0, 1, 4, 2, 0};
    vt[7] = '{32'h0000, 0, 1, 0, 1, 4, 1, 0};
    vt[8] = '{32'h0000, 0, 1, 0, 0, 0, 0, 0};
    vt[9] = '{32'hFFFF, 0, 1, 0, 0, 0, 0, 0};
    ovf_codes = '{1, 2, 3, 1};
    fp_codes  = '{2, 3, 1, 2};

    RST = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #3;
    chk("reset.valid", int'(RES_Valid), 0);
    chk("reset.code", int'(RES_Code), 0);
    chk("reset.count", int'(FIFO_Count), 0);
    chk("reset.overflow", int'(Overflow), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    check_model("post_reset");

    // Directed table: decode, one-cycle latency, ERR encodings, empty pop ignored
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].flag, vt[i].out, vt[i].ready, vt[i].clr);
      tick();
      chk($sformatf("vec%0d.valid", i), int'(RES_Valid), vt[i].exp_vld);
      chk($sformatf("vec%0d.code", i), int'(RES_Code), vt[i].exp_code);
      chk($sformatf("vec%0d.count", i), int'(FIFO_Count), vt[i].exp_cnt);
      chk($sformatf("vec%0d.overflow", i), int'(Overflow), vt[i].exp_ovf);
    end
    check_model("after_table");

    // Overflow: 5 pushes into a stalled 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      drive(1, (i == 4) ? 2 : ovf_codes[i], 0, 0);
      tick();
      if (i == 3) begin
        chk("ovf.count_at_4", int'(FIFO_Count), 4);
        chk("ovf.flag_at_4", int'(Overflow), 0);
      end
    end
    chk("ovf.count_at_5", int'(FIFO_Count), 4);
    chk("ovf.flag_at_5", int'(Overflow), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf.pop%0d", i), int'(RES_Code), ovf_codes[i]);
      drive(0, 0, 1, 0);
      tick();
    end
    chk("ovf.drained_count", int'(FIFO_Count), 0);
    chk("ovf.sticky", int'(Overflow), 1);
    drive(0, 0, 0, 1);
    tick();
    chk("clr.overflow", int'(Overflow), 0);
    check_model("after_clr");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1, ovf_codes[i], 0, 0);
      tick();
    end
    drive(1, 2, 1, 0);
    tick();
    chk("fullpp.count", int'(FIFO_Count), 4);
    chk("fullpp.overflow", int'(Overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpp.pop%0d", i), int'(RES_Code), fp_codes[i]);
      drive(0, 0, 1, 0);
      tick();
    end
    check_model("after_fullpp");

    // CLR and an overflow in the same cycle: set wins
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 0, 0);
      tick();
    end
    drive(1, 1, 0, 1);
    tick();
    chk("clr_vs_ovf.overflow", int'(Overflow), 1);
    drive(0, 0, 0, 1);
    tick();
    chk("clr_only.overflow", int'(Overflow), 0);
    chk("clr_only.count", int'(FIFO_Count), 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0);
      tick();
    end
    check_model("after_clr_vs_ovf");

`ifdef CMP_STATS_EN
    // Saturating counters with Cnt_Width=2
    drive(0, 0, 1, 1);
    tick();
    chk("stats.eq_cleared", int'(EQ_Cnt), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 0);
      tick();
    end
    chk("stats.eq_saturated", int'(EQ_Cnt), 3);
    drive(0, 0, 0, 1);
    tick();
    chk("stats.clr_eq", int'(EQ_Cnt), 0);
    chk("stats.clr_gt", int'(GT_Cnt), 0);
    chk("stats.clr_lt", int'(LT_Cnt), 0);
    chk("stats.clr_overflow", int'(Overflow), 0);
    chk("stats.clr_count", int'(FIFO_Count), 1);
    drive(0, 0, 1, 0);
    tick();
    check_model("after_stats");
`endif

    // Asynchronous reset with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, 0, 0);
      tick();
    end
    chk("arst.pre_count", int'(FIFO_Count), 3);
    #2;
    RST = 1'b0;
    #1;
    chk("arst.valid", int'(RES_Valid), 0);
    chk("arst.count", int'(FIFO_Count), 0);
    chk("arst.code", int'(RES_Code), 0);
    chk("arst.overflow", int'(Overflow), 0);
    model_reset();
    #2;
    RST = 1'b1;
    drive(1, 3, 0, 0);
    tick();
    chk("arst.new_code", int'(RES_Code), 3);
    chk("arst.new_count", int'(FIFO_Count), 1);
    drive(0, 0, 1, 0);
    tick();
    check_model("after_arst");

    // Randomized run: heavy stalls first, then mostly-ready traffic
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 3) != 0) ? 1 : 0;
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 5));
      if (i < 200) r = ($urandom_range(0, 3) == 0) ? 1 : 0;
      else r = ($urandom_range(0, 2) != 0) ? 1 : 0;
      c = ($urandom_range(0, 30) == 0) ? 1 : 0;
      drive(f, v, r, c);
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_result_collector.md
# cmp_result_collector

Receive-side companion of the ALU compare unit: samples the registered compare result (`CMP_Out`, `CMP_Flag`) every clock and decodes it into a 3-bit relation code. Queues the codes in a small show-ahead FIFO and hands them to the downstream consumer over a valid/ready handshake. Sits between the ALU compare unit and the result bus / controller, so compare results are never lost while the consumer stalls.

## Interface
- `Op_Width`, 16, width of `CMP_Out`.
- `Depth`, 4, FIFO entries; power of two, ≥2.
- `Cnt_Width`, 8, width of each statistics counter.
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset; one clock, asynchronous, active-low.
- `CMP_Out`  in  `Op_Width`  compare result from the ALU compare unit.
- `CMP_Flag`  in  1  result-valid strobe; one result per cycle it is high.
- `CLR`  in  1  synchronous clear of `Overflow` and the statistics counters; FIFO contents unaffected.
- `RES_Ready`  in  1  consumer accepts the head entry.
- `RES_Valid`  out  1  FIFO non-empty.
- `RES_Code`  out  3  head entry: 000 NONE, 001 EQ, 010 GT, 011 LT, 100 ERR.
- `FIFO_Count`  out  log2(`Depth`)+1  occupancy, 0..`Depth`.
- `Overflow`  out  1  sticky; set when a result is dropped.
- `EQ_Cnt`, `GT_Cnt`, `LT_Cnt`  out  `Cnt_Width` each  statistics (only with `CMP_STATS_EN`).

## Operation
- Decode when `CMP_Flag`=1:
  - `CMP_Out`=0 → NONE
  - 1 → EQ
  - 2 → GT
  - 3 → LT
  - any other value, including nonzero upper bits → ERR
- Push: when `CMP_Flag`=1, the decoded code is written at the write pointer.
- Pop: when `RES_Valid`=1 and `RES_Ready`=1, the read pointer advances.
- `RES_Ready` while empty is ignored.
- Pointers are log2(`Depth`) bits and wrap modulo `Depth`. The count is a separate register updated +1 / −1 / 0.
- Full and push with no pop: the result is dropped and `Overflow` is set. Pointers and count are unchanged.
- Full and push with pop in the same cycle: both happen, the count stays at `Depth`, and there is no overflow.
- Empty and push with `RES_Ready`=1: no bypass. The entry is written and becomes visible the next cycle.
- `CLR` and an overflow event in the same cycle: `Overflow` ends at 1 (set wins).
- Statistics counters:
  - `EQ_Cnt`, `GT_Cnt`, `LT_Cnt` increment on every decoded EQ / GT / LT.
  - They count whether or not the entry was dropped.
  - They saturate at all-ones.
  - `CLR` zeroes them; `CLR` wins over an increment in the same cycle.

## Timing
- Reset (`RST`=0, asynchronous): pointers and count are 0, `RES_Valid`=0, `RES_Code`=000, `FIFO_Count`=0, `Overflow`=0, all counters 0. This applies mid-operation: all queued entries are discarded immediately.
- Latency: result sampled at edge N → `RES_Valid`=1 with its code after edge N (visible during cycle N+1).
- `RES_Code` is driven from the FIFO head register and is stable while `RES_Valid`=1 and `RES_Ready`=0.
- `RES_Code` = 000 when empty.
- Sustained throughput is one result per cycle when `RES_Ready` is held high.
- `FIFO_Count` and `Overflow` update on the same edge as the push/pop that causes them.

## Configuration
- `CMP_STATS_EN` defined: the three saturating counters and their output ports exist, and `CLR` clears them.
- `CMP_STATS_EN` undefined: the counters and ports are absent, and `CLR` affects only `Overflow`. FIFO behaviour is identical in both builds.

## Test plan
- Reset, then `CMP_Flag`=1 with `CMP_Out`=1, 2, 3, 0 on consecutive cycles, `RES_Ready`=1 → `RES_Code` sequence 001, 010, 011, 000, each one cycle after its input. `FIFO_Count` never exceeds 1.
- `RES_Ready`=0, push 5 results with `Depth`=4 → `FIFO_Count`=4, `Overflow`=1 after the 5th push. Pops return only the first 4 codes, in order.
- Full FIFO, push and pop in the same cycle → `FIFO_Count` stays 4, `Overflow` stays 0, new code appears last.
- `CMP_Out`=16'h0100 and 16'h0004 → both produce ERR (100) and no counter increments.
- With `CMP_STATS_EN` and `Cnt_Width`=2, push EQ 5 times → `EQ_Cnt`=3 (saturated). `CLR`=1 for one cycle → counters 0, `Overflow` 0, `FIFO_Count` unchanged.
- Assert `RST`=0 mid-cycle with 3 entries queued → `RES_Valid`, `FIFO_Count`, and `RES_Code` drop to 0 without waiting for a clock edge. After release, the first new push is read back correctly.
